sd_sector_uart_tx: RTL and testbench
====================================

Name: sd_sector_uart_tx

Overview:
- Read-back path: reads a run of SD sectors through the sd_ctrl_top read interface and streams the bytes out through the uart_tx valid/ready interface.
- The SD read port has no backpressure, so each sector is first captured in a local word buffer, then drained byte by byte.
- Sits between sd_ctrl_top (rd_* signals) and uart_tx (tx_* signals), beside the UART-to-SD write path, in the clk_50m domain.

Parameters:
- BUF_WORDS, 256: 16-bit words per sector buffer (512-byte sector).
- BUSY_TIMEOUT, 50_000_000: cycles to wait for rd_busy to rise after a request before aborting (1 s at 50 MHz).

Ports:
- clk_50m  in  1  clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- init_end  in  1  SD initialisation complete.
- start  in  1  one-cycle command pulse.
- start_addr  in  32  first sector address, sampled on accepted start.
- sec_cnt  in  16  number of sectors, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run (normal or abort).
- err  out  1  sticky: timeout or overflow; cleared on next accepted start.
- rd_en  out  1  one-cycle read request to sd_ctrl_top.
- rd_addr  out  32  sector address, stable while rd_en is high and during the read.
- rd_busy  in  1  SD read in progress.
- rd_data_en  in  1  rd_data valid this cycle.
- rd_data  in  16  read word, high byte is the first byte on the card.
- tx_data  out  8  byte to uart_tx.
- tx_data_valid  out  1  byte valid.
- tx_data_ready  in  1  uart_tx ready; a transfer occurs when valid and ready are both high.

Behaviour:
- Reset values: busy, done, err, rd_en, tx_data_valid are 0; rd_addr and tx_data are 0; state is IDLE; all counters are 0.
- IDLE:
  - start is accepted only when init_end=1; start with init_end=0 is ignored.
  - On accept: latch start_addr into rd_addr and sec_cnt into remaining; set busy; clear err.
  - If sec_cnt=0: done pulses on the next cycle, busy drops in the same cycle, and no rd_en is issued.
  - Otherwise go to REQ.
- REQ: assert rd_en for exactly one cycle, clear word counter wcnt and timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - On rd_busy=1, go to READ.
  - If the timeout counter reaches BUSY_TIMEOUT: set err, go to FINISH.
  - rd_data_en pulses seen in this state are captured as in READ.
- READ:
  - Each rd_data_en cycle writes rd_data to buf[wcnt] and increments wcnt.
  - Writes with wcnt=BUF_WORDS are dropped and set err; wcnt saturates.
  - On rd_busy falling (1 to 0), go to DRAIN with nwords=wcnt.
- DRAIN:
  - Sends 2*nwords bytes in order buf[0][15:8], buf[0][7:0], buf[1][15:8], and so on.
  - Buffer read latency is 1 cycle.
  - tx_data_valid stays high with tx_data stable until tx_data_ready=1.
  - After each transfer, valid goes low for at least 1 cycle before the next byte is presented.
  - If nwords=0 (short read), no bytes are sent.
  - When all bytes are sent, go to NEXT.
- NEXT:
  - Decrement remaining; increment rd_addr by 1 with 32-bit wrap (0xFFFFFFFF to 0).
  - If remaining becomes 0, go to FINISH; else go to REQ.
- FINISH:
  - Pulse done for 1 cycle, drop busy in the same cycle, return to IDLE.
  - tx_data_valid is already low here.
- Boundary rules:
  - start while busy=1: ignored.
  - init_end dropping mid-run: ignored; the run continues and the timeout covers a dead card.
  - rst_n asserted mid-operation: immediate return to reset values; any byte in flight is abandoned, with tx_data_valid dropping asynchronously.
  - Buffer contents are not cleared by reset and are never sent unless written in the current sector.

Test Plan:
- Single sector: start_addr=0x00001000, sec_cnt=1; model returns words 0x0001..0x0100 with rd_busy high for 256 data beats → one rd_en with rd_addr=0x1000; 512 bytes out in the order 00,01,00,02,…,01,00; done once; err=0.
- Multi-sector with backpressure: sec_cnt=3, start_addr=0xFFFFFFFE, tx_data_ready toggling randomly → rd_addr sequence FFFFFFFE, FFFFFFFF, 00000000; 1536 bytes out, none lost or duplicated; tx_data stable while valid and not ready.
- Gating: start with init_end=0 → no rd_en, busy stays 0; second start while busy → ignored, byte count unchanged.
- Zero count: sec_cnt=0 → done 1 cycle after start; no rd_en, no tx_data_valid.
- Fault paths: rd_busy never rises with BUSY_TIMEOUT=100 → err=1 and done at cycle 100±2, no bytes sent. 260 rd_data_en beats in one sector → err=1; exactly 512 bytes sent, taken from the first 256 words.
- Reset mid-DRAIN after 10 bytes → all outputs return to reset values; a new start then runs cleanly with err=0.

Source files
------------

// File: rtl/sd_sector_uart_tx_if.sv
// SD read port and UART byte stream seen by the sector read-back path.
// The master side is the read-back block; the slave side is the SD controller and UART.
interface sd_sector_uart_tx_if;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_busy;
    logic        rd_data_en;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;

    modport master (
        output rd_en, rd_addr, tx_data, tx_data_valid,
        input  rd_busy, rd_data_en, rd_data, tx_data_ready
    );

    modport slave (
        input  rd_en, rd_addr, tx_data, tx_data_valid,
        output rd_busy, rd_data_en, rd_data, tx_data_ready
    );
endinterface

// File: rtl/sd_sector_uart_tx.sv
// Reads a run of SD sectors into a word buffer, one sector at a time, and
// streams each sector out to the UART as bytes, high byte of each word first.
module sd_sector_uart_tx #(
    parameter int BUF_WORDS    = 256,
    parameter int BUSY_TIMEOUT = 50_000_000
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                init_end,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [15:0]         sec_cnt,
    output logic                busy,
    output logic                done,
    output logic                err,
    sd_sector_uart_tx_if.master bus
);
    localparam int AW = $clog2(BUF_WORDS);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0]   WMAX     = (AW+1)'(BUF_WORDS);
    localparam logic [TW-1:0] TMR_LOAD = TW'(BUSY_TIMEOUT);

    // state     | meaning
    // IDLE      | waiting for start with init_end high
    // REQ       | one-cycle rd_en, counters cleared
    // WAIT_BUSY | waiting for rd_busy to rise, timeout running
    // READ      | capturing words until rd_busy falls
    // DRAIN     | all bytes sent? else address the buffer word
    // DRAIN_LD  | buffer word available, present byte
    // DRAIN_TX  | byte valid, waiting for tx_data_ready
    // NEXT      | advance sector address and count
    // FINISH    | done pulse, busy drops
    typedef enum logic [3:0] {
        IDLE, REQ, WAIT_BUSY, READ, DRAIN, DRAIN_LD, DRAIN_TX, NEXT, FINISH
    } state_t;

    state_t        state;
    logic [15:0]   remaining;
    logic [AW:0]   wcnt;
    logic [AW+1:0] bcnt;
    logic [TW-1:0] tmr;
    logic [15:0]   rdata;
    logic [15:0]   mem [BUF_WORDS];
    logic          capture;
    logic          wr_en;

    assign capture = ((state == WAIT_BUSY) || (state == READ)) && bus.rd_data_en;
    assign wr_en   = capture && (wcnt < WMAX);

    // Buffer has no reset; stale words are never sent because draining stops at wcnt.
    always_ff @(posedge clk_50m) begin
        if (wr_en) mem[wcnt[AW-1:0]] <= bus.rd_data;
        rdata <= mem[bcnt[AW:1]];
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            bus.rd_en         <= 1'b0;
            bus.rd_addr       <= 32'd0;
            bus.tx_data       <= 8'd0;
            bus.tx_data_valid <= 1'b0;
            remaining         <= 16'd0;
            wcnt              <= '0;
            bcnt              <= '0;
            tmr               <= '0;
        end else begin
            done      <= 1'b0;
            bus.rd_en <= 1'b0;

            if (wr_en)
                wcnt <= wcnt + 1'b1;
            else if (capture)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start && init_end) begin
                        bus.rd_addr <= start_addr;
                        remaining   <= sec_cnt;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        state       <= (sec_cnt == 16'd0) ? FINISH : REQ;
                    end
                end
                REQ: begin
                    bus.rd_en <= 1'b1;
                    wcnt      <= '0;
                    tmr       <= TMR_LOAD;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.rd_busy) begin
                        state <= READ;
                    end else if (tmr == TW'(1)) begin
                        err   <= 1'b1;
                        state <= FINISH;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                READ: begin
                    // READ is only held while rd_busy is high, so low here is the falling edge
                    if (!bus.rd_busy) begin
                        bcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= (bcnt == {wcnt, 1'b0}) ? NEXT : DRAIN_LD;
                end
                DRAIN_LD: begin
                    bus.tx_data       <= bcnt[0] ? rdata[7:0] : rdata[15:8];
                    bus.tx_data_valid <= 1'b1;
                    state             <= DRAIN_TX;
                end
                DRAIN_TX: begin
                    if (bus.tx_data_ready) begin
                        bus.tx_data_valid <= 1'b0;
                        bcnt              <= bcnt + 1'b1;
                        state             <= DRAIN;
                    end
                end
                NEXT: begin
                    remaining   <= remaining - 16'd1;
                    bus.rd_addr <= bus.rd_addr + 32'd1;
                    state       <= (remaining == 16'd1) ? FINISH : REQ;
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_uart_tx.sv
// Scoreboard bench: an SD card model pushes the bytes each sector should produce,
// and a UART-side monitor pops and compares every accepted byte.
`timescale 1ns/1ps
module tb_sd_sector_uart_tx;
    localparam int TMO = 100;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic [15:0] sec_cnt = 16'd0;
    logic        busy, done, err;

    sd_sector_uart_tx_if ifc ();

    sd_sector_uart_tx #(.BUF_WORDS(256), .BUSY_TIMEOUT(TMO)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .init_end   (init_end),
        .start      (start),
        .start_addr (start_addr),
        .sec_cnt    (sec_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (ifc)
    );

    always #10 clk_50m = ~clk_50m;

    int errors = 0, checks = 0;
    int byte_cnt = 0, rden_cnt = 0, done_cnt = 0;
    int sd_mode = 0;     // 0: words 1..N, 1: random words, 2: card never goes busy
    int sd_beats = 256;
    int rand_ready = 0;
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addr [$];
    bit          stall = 1'b0, last_xfer = 1'b0;
    logic [7:0]  held = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input int act);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d outside the required range", name, act);
        end
    endtask

    task automatic fail_msg(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, none was required", name, act);
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #2;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        tick();
        start_addr = a;
        sec_cnt    = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        bit seen = 1'b0;
        n = 0;
        while (n < budget && !seen) begin
            @(negedge clk_50m);
            n++;
            if (done) seen = 1'b1;
        end
        if (!seen) fail_msg("done_timeout", n);
    endtask

    // Card model: after each request, raise busy, deliver sd_beats words, drop busy.
    task automatic serve_sector();
        logic [15:0] w;
        repeat (2 + $urandom_range(0, 3)) @(posedge clk_50m);
        #2 ifc.rd_busy = 1'b1;
        for (int i = 0; i < sd_beats; i++) begin
            tick();
            w = (sd_mode == 0) ? 16'(i + 1) : 16'($urandom);
            ifc.rd_data    = w;
            ifc.rd_data_en = 1'b1;
            if (i < 256) begin
                exp_bytes.push_back(w[15:8]);
                exp_bytes.push_back(w[7:0]);
            end
            tick();
            ifc.rd_data_en = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        ifc.rd_busy = 1'b0;
    endtask

    initial begin
        ifc.rd_busy    = 1'b0;
        ifc.rd_data_en = 1'b0;
        ifc.rd_data    = 16'd0;
        forever begin
            @(negedge clk_50m);
            if (rst_n && ifc.rd_en) begin
                rden_cnt++;
                if (exp_addr.size() == 0) fail_msg("unexpected_rd_en", int'(ifc.rd_addr));
                else chk("rd_addr", ifc.rd_addr, exp_addr.pop_front());
                if (sd_mode != 2) serve_sector();
            end
        end
    end

    initial begin
        ifc.tx_data_ready = 1'b0;
        forever begin
            tick();
            ifc.tx_data_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_50m);
            if (!rst_n) begin
                stall     = 1'b0;
                last_xfer = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (stall) begin
                    chk("tx_valid_held", ifc.tx_data_valid, 1);
                    chk("tx_data_stable", ifc.tx_data, held);
                end
                if (last_xfer) chk("tx_valid_gap", ifc.tx_data_valid, 0);
                last_xfer = ifc.tx_data_valid && ifc.tx_data_ready;
                if (last_xfer) begin
                    byte_cnt++;
                    if (exp_bytes.size() == 0) fail_msg("unexpected_byte", int'(ifc.tx_data));
                    else chk("tx_byte", ifc.tx_data, exp_bytes.pop_front());
                end
                stall = ifc.tx_data_valid && !ifc.tx_data_ready;
                held  = ifc.tx_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0, r0, d0;
        bit busy_seen;

        #35;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", ifc.rd_en, 0);
        chk("rst_rd_addr", ifc.rd_addr, 0);
        chk("rst_tx_data", ifc.tx_data, 0);
        chk("rst_tx_valid", ifc.tx_data_valid, 0);
        rst_n = 1'b1;
        init_end = 1'b1;
        tick();
        tick();

        // single sector, counting pattern, ready always high
        b0 = byte_cnt; r0 = rden_cnt; d0 = done_cnt;
        exp_addr.push_back(32'h0000_1000);
        pulse_start(32'h0000_1000, 16'd1);
        wait_done(20000, n);
        tick();
        chk("t1_bytes", byte_cnt - b0, 512);
        chk("t1_rden", rden_cnt - r0, 1);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_left", exp_bytes.size(), 0);

        // three sectors across the address wrap, random backpressure, extra start while busy
        sd_mode = 1; rand_ready = 1;
        b0 = byte_cnt; r0 = rden_cnt; d0 = done_cnt;
        exp_addr.push_back(32'hFFFF_FFFE);
        exp_addr.push_back(32'hFFFF_FFFF);
        exp_addr.push_back(32'h0000_0000);
        pulse_start(32'hFFFF_FFFE, 16'd3);
        repeat (50) tick();
        chk("t2_busy_mid", busy, 1);
        pulse_start(32'h1234_5678, 16'd5);
        wait_done(40000, n);
        tick();
        chk("t2_bytes", byte_cnt - b0, 1536);
        chk("t2_rden", rden_cnt - r0, 3);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_err", err, 0);
        chk("t2_addr_left", exp_addr.size(), 0);
        chk("t2_left", exp_bytes.size(), 0);

        // start ignored while init_end is low
        init_end = 1'b0;
        r0 = rden_cnt; busy_seen = 1'b0;
        pulse_start(32'h0000_2000, 16'd1);
        repeat (20) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        chk("gate_busy", busy_seen, 0);
        chk("gate_rden", rden_cnt - r0, 0);
        init_end = 1'b1;

        // card never goes busy: timeout abort
        sd_mode = 2;
        b0 = byte_cnt; r0 = rden_cnt;
        exp_addr.push_back(32'h0000_4000);
        pulse_start(32'h0000_4000, 16'd2);
        wait_done(300, n);
        chk_ok("tmo_latency", n >= TMO - 2 && n <= TMO + 4, n);
        chk("tmo_err", err, 1);
        chk("tmo_rden", rden_cnt - r0, 1);
        chk("tmo_bytes", byte_cnt - b0, 0);
        tick();

        // zero count: quick done, nothing issued, err from the abort cleared
        b0 = byte_cnt; r0 = rden_cnt;
        pulse_start(32'h0000_3000, 16'd0);
        wait_done(10, n);
        chk_ok("zero_latency", n >= 1 && n <= 3, n);
        chk("zero_err", err, 0);
        chk("zero_rden", rden_cnt - r0, 0);
        chk("zero_bytes", byte_cnt - b0, 0);
        tick();

        // 260 beats into a 256-word buffer
        sd_mode = 1; sd_beats = 260; rand_ready = 0;
        b0 = byte_cnt;
        exp_addr.push_back(32'h0000_5000);
        pulse_start(32'h0000_5000, 16'd1);
        wait_done(20000, n);
        tick();
        chk("ovf_err", err, 1);
        chk("ovf_bytes", byte_cnt - b0, 512);
        chk("ovf_left", exp_bytes.size(), 0);
        sd_beats = 256;

        // reset after 10 bytes of a drain, then a clean run
        rand_ready = 1;
        b0 = byte_cnt; n = 0;
        exp_addr.push_back(32'h0000_6000);
        pulse_start(32'h0000_6000, 16'd4);
        while (byte_cnt - b0 < 10 && n < 20000) begin
            @(negedge clk_50m);
            n++;
        end
        if (byte_cnt - b0 < 10) fail_msg("rst_drain_timeout", byte_cnt - b0);
        @(posedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", ifc.tx_data_valid, 0);
        chk("mid_rst_tx_data", ifc.tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_addr", ifc.rd_addr, 0);
        chk("mid_rst_rd_en", ifc.rd_en, 0);
        chk("mid_rst_done", done, 0);
        exp_bytes.delete();
        exp_addr.delete();
        #45 rst_n = 1'b1;
        tick();
        b0 = byte_cnt; d0 = done_cnt;
        exp_addr.push_back(32'h0000_7000);
        pulse_start(32'h0000_7000, 16'd1);
        wait_done(20000, n);
        tick();
        chk("post_rst_bytes", byte_cnt - b0, 512);
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", err, 0);
        chk("post_rst_left", exp_bytes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
